// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide sequencer that owns HI/LO.
// Fixed mult/div latencies are modelled with a down-counter; busy stalls HI/LO readers.
module md_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned DataW = 32;
  localparam int unsigned CntW  = 4;
  localparam int unsigned OpW   = 3;

  localparam logic [OpW-1:0] OP_MULT  = OpW'(1);
  localparam logic [OpW-1:0] OP_MULTU = OpW'(2);
  localparam logic [OpW-1:0] OP_DIV   = OpW'(3);
  localparam logic [OpW-1:0] OP_DIVU  = OpW'(4);
  localparam logic [OpW-1:0] OP_MTHI  = OpW'(5);
  localparam logic [OpW-1:0] OP_MTLO  = OpW'(6);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic [OpW-1:0]     op_q;
  logic [DataW-1:0]   a_q, b_q;
  logic [DataW-1:0]   hi_q, lo_q;
  logic               busy_q, done_q;

  logic [DataW-1:0]   res_hi_d, res_lo_d;
  logic               res_we_d;

  logic [2*DataW-1:0] a_wide, b_wide, prod;
  logic               is_signed_div, a_neg, b_neg;
  logic [DataW-1:0]   a_mag, b_mag, divisor, q_mag, r_mag, quo, rem;

  // Result datapath on the latched operands. Signed divide runs on magnitudes
  // so 0x80000000 / -1 wraps to 0x80000000 instead of overflowing.
  always_comb begin
    a_wide = (op_q == OP_MULT) ? {{DataW{a_q[DataW-1]}}, a_q} : {{DataW{1'b0}}, a_q};
    b_wide = (op_q == OP_MULT) ? {{DataW{b_q[DataW-1]}}, b_q} : {{DataW{1'b0}}, b_q};
    prod   = a_wide * b_wide;

    is_signed_div = (op_q == OP_DIV);
    a_neg   = is_signed_div & a_q[DataW-1];
    b_neg   = is_signed_div & b_q[DataW-1];
    a_mag   = a_neg ? (DataW'(0) - a_q) : a_q;
    b_mag   = b_neg ? (DataW'(0) - b_q) : b_q;
    divisor = (b_q == '0) ? DataW'(1) : b_mag;
    q_mag   = a_mag / divisor;
    r_mag   = a_mag % divisor;
    quo     = (a_neg ^ b_neg) ? (DataW'(0) - q_mag) : q_mag;
    rem     = a_neg ? (DataW'(0) - r_mag) : r_mag;

    res_hi_d = hi_q;
    res_lo_d = lo_q;
    res_we_d = 1'b0;
    if (op_q == OP_MULT || op_q == OP_MULTU) begin
      res_hi_d = prod[2*DataW-1:DataW];
      res_lo_d = prod[DataW-1:0];
      res_we_d = 1'b1;
    end else if (op_q == OP_DIV || op_q == OP_DIVU) begin
      res_hi_d = rem;
      res_lo_d = quo;
      res_we_d = (b_q != '0);
    end
  end

  // Sequencer: issue in IDLE, count down in RUN, commit on the last busy cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == S_IDLE) begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              op_q    <= op;
              a_q     <= a;
              b_q     <= b;
              cnt_q   <= CntW'(MULT_CYCLES);
              busy_q  <= 1'b1;
              state_q <= S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              op_q    <= op;
              a_q     <= a;
              b_q     <= b;
              cnt_q   <= CntW'(DIV_CYCLES);
              busy_q  <= 1'b1;
              state_q <= S_RUN;
            end
            OP_MTHI: hi_q <= a;
            OP_MTLO: lo_q <= a;
            default: ;
          endcase
        end
      end else begin
        // Any start seen here is dropped; the hazard unit never issues one.
        if (cnt_q == CntW'(1)) begin
          if (res_we_d) begin
            hi_q <= res_hi_d;
            lo_q <= res_lo_d;
          end
          cnt_q   <= '0;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end else begin
          cnt_q <= cnt_q - CntW'(1);
        end
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Randomized bench for md_sequencer against a 64-bit arithmetic reference model.
module tb_md_sequencer;

  localparam int unsigned MULT_C = 5;
  localparam int unsigned DIV_C  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  always #5 clk = ~clk;

  md_sequencer #(.MULT_CYCLES(MULT_C), .DIV_CYCLES(DIV_C)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: architectural effect of one op on HI/LO, using plain 64-bit arithmetic.
  function automatic void model(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                                inout logic [31:0] h, inout logic [31:0] l);
    longint          sp, sa, sb, q, r;
    longint unsigned up, ua, ub;
    case (o)
      3'd1: begin
        sp = longint'($signed(av)) * longint'($signed(bv));
        h = sp[63:32]; l = sp[31:0];
      end
      3'd2: begin
        ua = longint'(av); ub = longint'(bv); up = ua * ub;
        h = up[63:32]; l = up[31:0];
      end
      3'd3: if (bv != 0) begin
        sa = longint'($signed(av)); sb = longint'($signed(bv));
        q = sa / sb; r = sa % sb;
        h = r[31:0]; l = q[31:0];
      end
      3'd4: if (bv != 0) begin
        ua = longint'(av); ub = longint'(bv);
        h = 32'(ua % ub); l = 32'(ua / ub);
      end
      3'd5: h = av;
      3'd6: l = av;
      default: ;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] o);
    if (o == 3'd1 || o == 3'd2) return MULT_C;
    if (o == 3'd3 || o == 3'd4) return DIV_C;
    return 0;
  endfunction

  // Issue one op at a negedge; returns at the negedge of the first post-op cycle.
  task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input bit poke, input bit gap);
    int          exp_c;
    int          cnt;
    logic [31:0] nh, nl;
    exp_c = latency(o);
    nh = exp_hi; nl = exp_lo;
    model(o, av, bv, nh, nl);
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; op = 3'd0; a = $urandom; b = $urandom;
    if (exp_c == 0) begin
      exp_hi = nh; exp_lo = nl;
      check_eq("idle_op_busy", busy, 0);
      check_eq("idle_op_done", done, 0);
      check_eq("idle_op_hi", hi, exp_hi);
      check_eq("idle_op_lo", lo, exp_lo);
    end else begin
      cnt = 0;
      while (busy === 1'b1 && cnt < 40) begin
        cnt++;
        check_eq("run_done", done, 0);
        check_eq("run_hi_hold", hi, exp_hi);
        check_eq("run_lo_hold", lo, exp_lo);
        if (poke && cnt == 2) begin
          start = 1'b1; op = 3'd6; a = 32'hDEADBEEF; b = $urandom;
        end else begin
          start = 1'b0; op = 3'd0; a = $urandom; b = $urandom;
        end
        @(negedge clk);
      end
      start = 1'b0; op = 3'd0;
      exp_hi = nh; exp_lo = nl;
      check_eq("busy_len", 64'(cnt), 64'(exp_c));
      check_eq("done_pulse", done, 1);
      check_eq("busy_after", busy, 0);
      check_eq("res_hi", hi, exp_hi);
      check_eq("res_lo", lo, exp_lo);
    end
    if (gap) begin
      @(negedge clk);
      check_eq("gap_done", done, 0);
      check_eq("gap_busy", busy, 0);
    end
  endtask

  task automatic reset_mid_mult();
    start = 1'b1; op = 3'd1; a = 32'h1234; b = 32'h5678;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    for (int i = 0; i < 2; i++) begin
      check_eq("rst_pre_busy", busy, 1);
      @(negedge clk);
    end
    check_eq("rst_pre_busy3", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_hi", hi, 0);
    check_eq("rst_lo", lo, 0);
    repeat (MULT_C + 1) begin
      @(negedge clk);
      check_eq("rst_no_done", done, 0);
      check_eq("rst_no_busy", busy, 0);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    int unsigned k;
    k = $urandom_range(0, 9);
    case (k)
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      5: return 32'(int'($urandom_range(0, 20)) - 10);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_hi", hi, 0);
    check_eq("reset_lo", lo, 0);

    issue(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b1);
    check_eq("tp_mult_hi", hi, 32'hFFFFFFFF);
    check_eq("tp_mult_lo", lo, 32'hFFFFFFFA);

    issue(3'd2, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0);
    check_eq("tp_multu_hi", hi, 32'h00000001);
    check_eq("tp_multu_lo", lo, 32'hFFFFFFFE);

    issue(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    check_eq("tp_div_lo", lo, 32'hFFFFFFFD);
    check_eq("tp_div_hi", hi, 32'hFFFFFFFF);

    issue(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1);
    check_eq("tp_divovf_lo", lo, 32'h80000000);
    check_eq("tp_divovf_hi", hi, 32'h0);

    issue(3'd5, 32'h12345678, 32'h0, 1'b0, 1'b0);
    check_eq("tp_mthi", hi, 32'h12345678);
    issue(3'd6, 32'h9ABCDEF0, 32'h0, 1'b0, 1'b0);
    check_eq("tp_mtlo", lo, 32'h9ABCDEF0);

    issue(3'd4, 32'h55, 32'h0, 1'b0, 1'b1);
    check_eq("tp_div0_hi", hi, 32'h12345678);
    check_eq("tp_div0_lo", lo, 32'h9ABCDEF0);

    issue(3'd3, 32'd100, 32'd7, 1'b1, 1'b1);
    check_eq("tp_poke_lo", lo, 32'd14);
    check_eq("tp_poke_hi", hi, 32'd2);

    issue(3'd0, 32'hAAAA5555, 32'h1, 1'b0, 1'b0);
    issue(3'd7, 32'hAAAA5555, 32'h1, 1'b0, 1'b0);

    reset_mid_mult();
    issue(3'd2, 32'd6, 32'd7, 1'b0, 1'b1);
    check_eq("tp_after_rst_lo", lo, 32'd42);
    check_eq("tp_after_rst_hi", hi, 32'd0);

    for (int i = 0; i < 150; i++) begin
      issue(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multi-cycle multiply/divide sequencer for the pipelined MIPS core. It sits beside the E-stage ALU and accepts one mult/multu/div/divu/mthi/mtlo request per issue. It holds the HI/LO architectural registers, models the fixed multiply and divide latencies with a down-counter, and raises `busy` so the hazard unit can stall any later HI/LO-dependent instruction in D.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu; legal range 1..15.
- `DIV_CYCLES`, default 10: busy cycles for div/divu; legal range 1..15.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high reset, sampled on posedge `clk`.
- `start`, in, 1: issue strobe from the E stage.
- `op`, in, 3: operation code.
  - 0: none.
  - 1: mult.
  - 2: multu.
  - 3: div.
  - 4: divu.
  - 5: mthi.
  - 6: mtlo.
  - 7: reserved, treated as none.
- `a`, in, 32: rs operand (dividend / multiplicand / mthi-mtlo source).
- `b`, in, 32: rt operand (divisor / multiplier).
- `busy`, out, 1: a multiply or divide is in flight.
- `done`, out, 1: one-cycle pulse in the first cycle that the new HI/LO values are visible.
- `hi`, out, 32: HI register.
- `lo`, out, 32: LO register.

## Operation
- Two states: IDLE and RUN. Registers:
  - `cnt` (4 bits).
  - `op_q`.
  - `a_q`, `b_q`.
  - `hi`, `lo`.
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, `cnt`=0, state IDLE.
- **IDLE, start with op 1–4:**
  - Latch `op`, `a`, `b`.
  - Load `cnt` with `MULT_CYCLES` (op 1–2) or `DIV_CYCLES` (op 3–4).
  - Go to RUN.
- **IDLE, start with op 5:** `hi` <= `a` at that edge. Stay IDLE, no `busy`, no `done`.
- **IDLE, start with op 6:** `lo` <= `a` at that edge. Stay IDLE, no `busy`, no `done`.
- **IDLE, start with op 0 or 7:** no effect.
- **RUN:**
  - `cnt` decrements each edge.
  - At the edge where `cnt`==1, commit the result to `hi`/`lo`, assert `done` for the next cycle, and return to IDLE.
- **Any `start` while in RUN:** ignored entirely, including mthi/mtlo. The hazard unit guarantees this never happens; the bench checks that it is harmless.
- **Arithmetic (on latched operands):**
  - mult: signed 64-bit product of `a_q`×`b_q`; `hi`=[63:32], `lo`=[31:0].
  - multu: unsigned product, same split.
  - div: `lo` = signed quotient truncated toward zero; `hi` = remainder, carrying the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Signed div of 0x80000000 by 0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
- **Divide by zero (div or divu with `b_q`=0):**
  - Full `DIV_CYCLES` busy period still occurs.
  - `hi`/`lo` stay unchanged.
  - `done` still pulses.
- Operands are captured at `start`; changes on `a`/`b` during RUN do not affect the result.
- **`reset` asserted mid-RUN:**
  - Aborts the operation.
  - Returns all state to reset values at that edge.
  - No commit, no `done`.

## Timing
- `start` is sampled at edge N.
- `busy`=1 from cycle N+1 through cycle N+C inclusive, where C is `MULT_CYCLES` or `DIV_CYCLES`. That is exactly C cycles.
- `hi`/`lo` update at the edge ending cycle N+C.
- Cycle N+C+1: `busy`=0, `done`=1, new `hi`/`lo` visible.
- A new `start` may be sampled at edge N+C+1, giving back-to-back operations with no idle cycle.
- mthi/mtlo: value visible in cycle N+1; `busy` never rises.
- `busy` is registered; `busy` and `done` are never both 1.
- `hi` and `lo` never change while `busy`=1.

## Test plan
- **Reset, then mult:**
  - Stimulus: `start`, op=1, a=0xFFFFFFFE (−2), b=3.
  - `busy` high exactly 5 cycles.
  - Then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA, with a single `done` pulse.
- **multu:**
  - Stimulus: a=0xFFFFFFFF, b=2.
  - Result after 5 cycles: `hi`=0x00000001, `lo`=0xFFFFFFFE.
- **Signed division corners:**
  - div a=−7 (0xFFFFFFF9), b=2: after 10 busy cycles `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - Then div 0x80000000 by 0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
- **Divide by zero and HI/LO moves:**
  - mthi a=0x12345678 → `hi`=0x12345678 next cycle, `busy` stays 0.
  - mtlo a=0x9ABCDEF0 → `lo`=0x9ABCDEF0 next cycle, `busy` stays 0.
  - divu b=0 → 10 busy cycles, `done` pulses, `hi`/`lo` unchanged.
- **Start during RUN:**
  - During a div, pulse `start` op=6 with a=0xDEADBEEF, and also change `a`/`b`.
  - Required: `lo` ≠ 0xDEADBEEF, the result matches the originally latched operands, and the busy length is unchanged.
- **Reset mid-RUN:**
  - Assert `reset` in the 3rd busy cycle of a mult.
  - Next cycle: `busy`=0, `hi`=`lo`=0, and `done` never pulses.
  - A following multu 6×7 then yields `lo`=42, `hi`=0 after 5 cycles.
